// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply, restoring
// divide, and ownership of the architectural HI/LO registers.
module ex_muldiv_unit #(
  parameter int BUS_SIZE  = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_is_rtype,
  input  logic [5:0]          i_funct,
  input  logic [BUS_SIZE-1:0] i_op_a,
  input  logic [BUS_SIZE-1:0] i_op_b,
  input  logic                i_flush,
  output logic                o_busy,
  output logic                o_stall,
  output logic                o_done,
  output logic [BUS_SIZE-1:0] o_result,
  output logic [BUS_SIZE-1:0] o_hi,
  output logic [BUS_SIZE-1:0] o_lo
);

  localparam int W = BUS_SIZE;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state_reg, state_next;
  logic [W-1:0]         hi_reg, hi_next;
  logic [W-1:0]         lo_reg, lo_next;
  logic [W-1:0]         opnd_reg, opnd_next;
  logic [2*W-1:0]       work_reg, work_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 is_div_reg, is_div_next;
  logic                 dz_reg, dz_next;
  logic                 neg_res_reg, neg_res_next;
  logic                 neg_rem_reg, neg_rem_next;
  logic                 done_reg, done_next;

  // Instruction decode: funct 0110xx = mult/div, 0100xx = HI/LO moves.
  // Bit 0 selects unsigned (mult/div) or move-to (moves); bit 1 selects div or LO.
  logic act, is_md, is_mv, is_mf, is_mt, is_signed_op;
  assign act          = i_valid & i_is_rtype;
  assign is_md        = act & (i_funct[5:2] == 4'b0110);
  assign is_mv        = act & (i_funct[5:2] == 4'b0100);
  assign is_mf        = is_mv & ~i_funct[0];
  assign is_mt        = is_mv & i_funct[0];
  assign is_signed_op = ~i_funct[0];

  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  assign a_neg = is_signed_op & i_op_a[W-1];
  assign b_neg = is_signed_op & i_op_b[W-1];
  assign a_mag = a_neg ? -i_op_a : i_op_a;
  assign b_mag = b_neg ? -i_op_b : i_op_b;

  // Multiply: work = {partial product, remaining multiplier bits}, shifted right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step;
  assign mul_sum  = {1'b0, work_reg[2*W-1:W]} + (work_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
  assign mul_step = {mul_sum, work_reg[W-1:1]};

  // Divide: work = {partial remainder, dividend/quotient}, shifted left.
  logic [W:0]     div_shift, div_diff;
  logic [2*W-1:0] div_step;
  assign div_shift = work_reg[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_step  = div_diff[W] ? {div_shift[W-1:0], work_reg[W-2:0], 1'b0}
                                 : {div_diff[W-1:0], work_reg[W-2:0], 1'b1};

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot, rem;
  assign prod_fix = neg_res_reg ? -work_reg : work_reg;
  assign quot     = work_reg[W-1:0];
  assign rem      = work_reg[2*W-1:W];

  logic last_iter;
  assign last_iter = (cnt_reg == CNT_WIDTH'(W - 1));

  always_comb begin
    state_next   = state_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    opnd_next    = opnd_reg;
    work_next    = work_reg;
    cnt_next     = cnt_reg;
    is_div_next  = is_div_reg;
    dz_next      = dz_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;
    done_next    = 1'b0;
    if (i_flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_md) begin
            is_div_next  = i_funct[1];
            cnt_next     = '0;
            neg_res_next = a_neg ^ b_neg;
            neg_rem_next = a_neg;
            dz_next      = 1'b0;
            if (i_funct[1]) begin
              if (i_op_b == '0) begin
                // Divide by zero skips iteration; raw dividend is kept for HI.
                dz_next    = 1'b1;
                work_next  = {{W{1'b0}}, i_op_a};
                state_next = FIX;
              end else begin
                work_next  = {{W{1'b0}}, a_mag};
                opnd_next  = b_mag;
                state_next = DIV;
              end
            end else begin
              work_next  = {{W{1'b0}}, b_mag};
              opnd_next  = a_mag;
              state_next = MUL;
            end
          end else if (is_mt) begin
            if (i_funct[1]) lo_next = i_op_a;
            else            hi_next = i_op_a;
          end
        end
        MUL: begin
          work_next = mul_step;
          cnt_next  = cnt_reg + CNT_WIDTH'(1);
          if (last_iter) state_next = FIX;
        end
        DIV: begin
          work_next = div_step;
          cnt_next  = cnt_reg + CNT_WIDTH'(1);
          if (last_iter) state_next = FIX;
        end
        FIX: begin
          if (dz_reg) begin
            lo_next = '1;
            hi_next = work_reg[W-1:0];
          end else if (is_div_reg) begin
            lo_next = neg_res_reg ? -quot : quot;
            hi_next = neg_rem_reg ? -rem : rem;
          end else begin
            hi_next = prod_fix[2*W-1:W];
            lo_next = prod_fix[W-1:0];
          end
          done_next  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      hi_reg      <= '0;
      lo_reg      <= '0;
      opnd_reg    <= '0;
      work_reg    <= '0;
      cnt_reg     <= '0;
      is_div_reg  <= 1'b0;
      dz_reg      <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      opnd_reg    <= opnd_next;
      work_reg    <= work_next;
      cnt_reg     <= cnt_next;
      is_div_reg  <= is_div_next;
      dz_reg      <= dz_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
      done_reg    <= done_next;
    end
  end

  assign o_busy   = (state_reg != IDLE);
  assign o_stall  = (is_md | is_mv) & o_busy;
  assign o_done   = done_reg;
  assign o_hi     = hi_reg;
  assign o_lo     = lo_reg;
  assign o_result = (is_mf & ~o_busy) ? (i_funct[1] ? lo_reg : hi_reg) : '0;

endmodule
